// File: rtl/soc_pkg.sv
// soc_pkg: shared FSM state type and APB bridge constants
package soc_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  localparam logic [3:0] PERIPH_TAG = 4'h4;
  localparam int SEL_LSB = 12;
  localparam int SEL_MSB = 13;
  localparam int APB_ADDR_W = 12;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/apb_decoder.sv
// apb_decoder: peripheral-window request, write select and one-hot slave select from the core address
module apb_decoder
  import soc_pkg::*;
#(
  parameter logic [3:0] TAG = PERIPH_TAG
) (
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  output logic        req,
  output logic        wr,
  output logic [3:0]  psel
);
  assign req  = (mem_read_i | mem_write_i) & (addr_i[31:28] == TAG);
  assign wr   = mem_write_i;
  assign psel = 4'b0001 << addr_i[SEL_MSB:SEL_LSB];
endmodule

// File: rtl/apb_stall_master.sv
// apb_stall_master: core load/store -> APB transfer bridge; stop_o holds the PC until DONE, rdata_o/err_o valid in DONE
module apb_stall_master
  import soc_pkg::*;
#(
  parameter logic [3:0]  PERIPH_TAG = soc_pkg::PERIPH_TAG,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_DATA   = soc_pkg::ERR_DATA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_write_i,
  input  logic                  mem_read_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stop_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic [3:0]            psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [APB_ADDR_W-1:0] paddr_o,
  output logic [31:0]           pwdata_o,
  input  logic [31:0]           prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic req, wr;
  logic [3:0] dec_psel;
  apb_decoder #(.TAG(PERIPH_TAG)) u_dec (
    .mem_read_i (mem_read_i),
    .mem_write_i(mem_write_i),
    .addr_i     (addr_i),
    .req        (req),
    .wr         (wr),
    .psel       (dec_psel)
  );
  // combinational from IDLE so the PC never steps past a peripheral access
  assign stop_o = rst_n & (((state == IDLE) & req) | (state == SETUP) | (state == ACCESS));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      psel_o    <= '0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            state    <= SETUP;
            psel_o   <= dec_psel;
            paddr_o  <= addr_i[APB_ADDR_W-1:0];
            pwdata_o <= wdata_i;
            pwrite_o <= wr;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (pready_i) begin
            state     <= DONE;
            psel_o    <= '0;
            penable_o <= 1'b0;
            rdata_o   <= pwrite_o ? rdata_o : prdata_i;
            err_o     <= pslverr_i;
          end else if (cnt == LAST) begin
            state     <= DONE;
            psel_o    <= '0;
            penable_o <= 1'b0;
            rdata_o   <= pwrite_o ? rdata_o : ERR_DATA;
            err_o     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // req is ignored here so the held instruction is not re-issued
          state <= IDLE;
          err_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_stall_master.sv
// tb_apb_stall_master: table-driven cycle vectors plus hand sequences for timeout and reset abort
module tb_apb_stall_master;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_write_i = 1'b0, mem_read_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0, prdata_i = '0;
  logic pready_i = 1'b0, pslverr_i = 1'b0;
  logic stop_o, err_o, penable_o, pwrite_o;
  logic [31:0] rdata_o, pwdata_o;
  logic [3:0] psel_o;
  logic [11:0] paddr_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  apb_stall_master dut (
    .clk(clk), .rst_n(rst_n), .mem_write_i(mem_write_i), .mem_read_i(mem_read_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stop_o(stop_o), .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );
  typedef struct packed {
    logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [31:0] prdata;
    logic pready; logic pslverr;
    logic e_stop; logic [3:0] e_psel; logic e_pen; logic e_pwr; logic [11:0] e_paddr;
    logic [31:0] e_pwdata; logic [31:0] e_rdata; logic e_err;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic s, input logic [3:0] ps, input logic pe,
                         input logic pw, input logic [11:0] pa, input logic [31:0] wd,
                         input logic [31:0] rd, input logic er);
    chk({tag, " stop"}, 32'(stop_o), 32'(s));
    chk({tag, " psel"}, 32'(psel_o), 32'(ps));
    chk({tag, " penable"}, 32'(penable_o), 32'(pe));
    chk({tag, " pwrite"}, 32'(pwrite_o), 32'(pw));
    chk({tag, " paddr"}, 32'(paddr_o), 32'(pa));
    chk({tag, " pwdata"}, pwdata_o, wd);
    chk({tag, " rdata"}, rdata_o, rd);
    chk({tag, " err"}, 32'(err_o), 32'(er));
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pr, input logic rdy, input logic se);
    mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = wd;
    prdata_i = pr; pready_i = rdy; pslverr_i = se;
  endtask
  initial begin
    int n, pen_n;
    // read zero wait, slave 1
    v.push_back('{1,0,32'h4000_1004,0,32'h1234_5678,1,0, 1,4'b0000,0,0,12'h000,0,0,0});
    v.push_back('{1,0,32'h4000_1004,0,32'h1234_5678,1,0, 1,4'b0010,0,0,12'h004,0,0,0});
    v.push_back('{1,0,32'h4000_1004,0,32'h1234_5678,1,0, 1,4'b0010,1,0,12'h004,0,0,0});
    v.push_back('{1,0,32'h4000_1004,0,32'h1234_5678,1,0, 0,4'b0000,0,0,12'h004,0,32'h1234_5678,0});
    v.push_back('{0,0,32'h0,0,0,1,0, 0,4'b0000,0,0,12'h004,0,32'h1234_5678,0});
    // write, 3 wait states, slave 3; rdata must stay put
    v.push_back('{0,1,32'h4000_3010,32'hA5A5_0001,0,0,0, 1,4'b0000,0,0,12'h004,0,32'h1234_5678,0});
    v.push_back('{0,1,32'h4000_3010,32'hA5A5_0001,0,0,0, 1,4'b1000,0,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    v.push_back('{0,1,32'h4000_3010,32'hA5A5_0001,0,0,0, 1,4'b1000,1,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    v.push_back('{0,1,32'h4000_3010,32'hA5A5_0001,0,0,0, 1,4'b1000,1,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    v.push_back('{0,1,32'h4000_3010,32'hA5A5_0001,0,0,0, 1,4'b1000,1,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    v.push_back('{0,1,32'h4000_3010,32'hA5A5_0001,32'hFFFF_FFFF,1,0, 1,4'b1000,1,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    v.push_back('{0,1,32'h4000_3010,32'hA5A5_0001,0,0,0, 0,4'b0000,0,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    v.push_back('{0,0,32'h0,0,0,0,0, 0,4'b0000,0,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    // non-peripheral load
    v.push_back('{1,0,32'h0000_0100,0,0,1,0, 0,4'b0000,0,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    v.push_back('{1,0,32'h0000_0100,0,0,1,0, 0,4'b0000,0,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    v.push_back('{1,0,32'h0000_0100,0,0,1,0, 0,4'b0000,0,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    // read with PSLVERR, slave 2
    v.push_back('{1,0,32'h4000_2008,0,32'hCAFE_F00D,1,1, 1,4'b0000,0,1,12'h010,32'hA5A5_0001,32'h1234_5678,0});
    v.push_back('{1,0,32'h4000_2008,0,32'hCAFE_F00D,1,1, 1,4'b0100,0,0,12'h008,0,32'h1234_5678,0});
    v.push_back('{1,0,32'h4000_2008,0,32'hCAFE_F00D,1,1, 1,4'b0100,1,0,12'h008,0,32'h1234_5678,0});
    v.push_back('{1,0,32'h4000_2008,0,32'hCAFE_F00D,1,0, 0,4'b0000,0,0,12'h008,0,32'hCAFE_F00D,1});
    v.push_back('{0,0,32'h0,0,0,1,0, 0,4'b0000,0,0,12'h008,0,32'hCAFE_F00D,0});
    // back-to-back reads, slave 0 then slave 1
    v.push_back('{1,0,32'h4000_0020,0,32'h1111_1111,1,0, 1,4'b0000,0,0,12'h008,0,32'hCAFE_F00D,0});
    v.push_back('{1,0,32'h4000_0020,0,32'h1111_1111,1,0, 1,4'b0001,0,0,12'h020,0,32'hCAFE_F00D,0});
    v.push_back('{1,0,32'h4000_0020,0,32'h1111_1111,1,0, 1,4'b0001,1,0,12'h020,0,32'hCAFE_F00D,0});
    v.push_back('{1,0,32'h4000_0020,0,32'h1111_1111,1,0, 0,4'b0000,0,0,12'h020,0,32'h1111_1111,0});
    v.push_back('{1,0,32'h4000_1030,0,32'h2222_2222,1,0, 1,4'b0000,0,0,12'h020,0,32'h1111_1111,0});
    v.push_back('{1,0,32'h4000_1030,0,32'h2222_2222,1,0, 1,4'b0010,0,0,12'h030,0,32'h1111_1111,0});
    v.push_back('{1,0,32'h4000_1030,0,32'h2222_2222,1,0, 1,4'b0010,1,0,12'h030,0,32'h1111_1111,0});
    v.push_back('{1,0,32'h4000_1030,0,32'h2222_2222,1,0, 0,4'b0000,0,0,12'h030,0,32'h2222_2222,0});
    v.push_back('{0,0,32'h0,0,0,1,0, 0,4'b0000,0,0,12'h030,0,32'h2222_2222,0});
    // reset state, with a peripheral request present to show stop is gated
    drive(1, 1, 32'h4000_1004, 32'h5555_5555, 0, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].rd, v[i].wr, v[i].addr, v[i].wdata, v[i].prdata, v[i].pready, v[i].pslverr);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), v[i].e_stop, v[i].e_psel, v[i].e_pen, v[i].e_pwr,
              v[i].e_paddr, v[i].e_pwdata, v[i].e_rdata, v[i].e_err);
      @(posedge clk); #1;
    end
    // timeout: read with pready stuck low
    drive(1, 0, 32'h4000_0040, 0, 32'h7777_7777, 0, 0);
    n = 0; pen_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stop_o) break;
      n++;
      if (penable_o) pen_n++;
      @(posedge clk); #1;
    end
    chk("timeout stop_cycles", 32'(n), 32'd18);
    chk("timeout access_cycles", 32'(pen_n), 32'd16);
    chk("timeout rdata", rdata_o, 32'hDEAD_BEEF);
    chk("timeout err", 32'(err_o), 32'd1);
    chk("timeout psel", 32'(psel_o), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("timeout err_pulse_end", 32'(err_o), 32'd0);
    chk("timeout idle_stop", 32'(stop_o), 32'd0);
    // reset while in ACCESS with pready low
    @(posedge clk); #1;
    drive(1, 0, 32'h4000_2000, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid in_access penable", 32'(penable_o), 32'd1);
    chk("rstmid in_access psel", 32'(psel_o), 32'b0100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid stop_during_reset", 32'(stop_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid psel", 32'(psel_o), 32'd0);
    chk("rstmid penable", 32'(penable_o), 32'd0);
    chk("rstmid err", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("rstmid after stop", 32'(stop_o), 32'd0);
    chk("rstmid after err", 32'(err_o), 32'd0);
    chk("rstmid after psel", 32'(psel_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid later err", 32'(err_o), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
